cipher_byte_tx: RTL and testbench



---
 rtl/cipher_tx_pkg.sv | 18 +
 rtl/cipher_byte_tx_if.sv | 29 ++
 rtl/tx_timeout_timer.sv | 29 ++
 rtl/cipher_byte_tx.sv | 126 ++++++++++++
 tb/tb_cipher_byte_tx.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cipher_tx_pkg.sv
// Shared types and sizes for the ciphertext byte transmitter.
package cipher_tx_pkg;

  localparam int unsigned BLK_BYTES = 16;
  localparam int unsigned ID_W      = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BLK_W     = BLK_BYTES * BYTE_W;
  localparam int unsigned IDX_W     = $clog2(BLK_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StSend,
    StGapw,
    StWaitDone
  } tx_state_e;

endpackage

// File: rtl/cipher_byte_tx_if.sv
// Upstream block handshake plus receiver-side byte stream and status.
interface cipher_byte_tx_if;
  import cipher_tx_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ID_W-1:0]   in_id;
  logic [BLK_W-1:0]  in_block;
  logic              rx_start;
  logic [ID_W-1:0]   rx_id;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_last;
  logic              rx_done;
  logic              busy;
  logic              timeout_err;
  logic [15:0]       blk_count;

  modport master (
    input  in_valid, in_id, in_block, rx_done,
    output in_ready, rx_start, rx_id, rx_data, rx_valid, rx_last, busy, timeout_err, blk_count
  );

  modport slave (
    output in_valid, in_id, in_block, rx_done,
    input  in_ready, rx_start, rx_id, rx_data, rx_valid, rx_last, busy, timeout_err, blk_count
  );

endinterface

// File: rtl/tx_timeout_timer.sv
// Down-counter that flags when TIMEOUT enabled cycles pass after a load.
module tx_timeout_timer #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CntW'(TIMEOUT - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Final enabled cycle of the window; a coincident rx_done takes priority upstream.
  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/cipher_byte_tx.sv
// Serializes one 128-bit block MSB-first to the receiver, then waits for rx_done.
// Optional done-timeout enabled by defining TX_TIMEOUT_EN.
module cipher_byte_tx
  import cipher_tx_pkg::*;
#(
  parameter int unsigned GAP     = 0,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic             clk,
  input logic             rstn,
  cipher_byte_tx_if.master bus
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BLK_BYTES - 1);

  tx_state_e         state_q;
  logic [BLK_W-1:0]  shreg_q;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        gap_q;
  logic              start_q;
  logic [ID_W-1:0]   id_q;
  logic [BYTE_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              err_q;
  logic [15:0]       count_q;
  logic              emit;
  logic              expire;

`ifdef TX_TIMEOUT_EN
  tx_timeout_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .load  ((state_q == StSend) && last_q),
    .en    (state_q == StWaitDone),
    .expire(expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire         = 1'b0;
`endif

  // A byte goes out in the cycle after emit is high.
  assign emit = (state_q == StStart) ||
                ((state_q == StSend) && !last_q && (GAP == 0)) ||
                ((state_q == StGapw) && (gap_q == '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      shreg_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      start_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= emit;
      last_q  <= emit && (idx_q == LastIdx);
      if (emit) begin
        data_q  <= shreg_q[BLK_W-1 -: BYTE_W];
        shreg_q <= shreg_q << BYTE_W;
        idx_q   <= idx_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            shreg_q <= bus.in_block;
            id_q    <= bus.in_id;
            idx_q   <= '0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: state_q <= StSend;
        StSend: begin
          if (last_q) begin
            state_q <= StWaitDone;
          end else if (GAP != 0) begin
            gap_q   <= 4'(GAP - 1);
            state_q <= StGapw;
          end
        end
        StGapw: begin
          if (gap_q == '0) state_q <= StSend;
          else             gap_q   <= gap_q - 1'b1;
        end
        StWaitDone: begin
          if (bus.rx_done) begin
            count_q <= count_q + 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (expire) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.rx_start    = start_q;
  assign bus.rx_id       = id_q;
  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.rx_last     = last_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
  assign bus.blk_count   = count_q;

endmodule

// File: tb/tb_cipher_byte_tx.sv
// Bench for cipher_byte_tx: GAP=0 and GAP=2 instances against a timing-rule model.
module tb_cipher_byte_tx;

  localparam int ToCyc = 64;
`ifdef TX_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  localparam int TA = 26;
  localparam int TC = 157;
  localparam int TD = 367;
  localparam int TE = 467;
  localparam int TF = 482;

  localparam logic [127:0] BlkA = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BlkB = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
  localparam logic [127:0] BlkC = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  typedef struct packed {
    logic [31:0]  id;
    logic [127:0] blk;
  } offer_t;

  logic   clk;
  logic   rstn;
  logic   done;
  int     cyc;
  int     errors;
  int     checks;
  bit     done_at [0:1023];
  offer_t offers[$];

  cipher_byte_tx_if bus_if [2] ();

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      done = (cyc < 1024) ? done_at[cyc] : 1'b0;
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  task automatic at_cycle(input int n);
    do @(negedge clk); while (cyc != n);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int G = 2 * g;
    // First cycle spent waiting for rx_done, relative to the handshake cycle.
    localparam int W = 2 + 15 * (G + 1) + 1;

    cipher_byte_tx #(
      .GAP    (G),
      .TIMEOUT(ToCyc)
    ) u_dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus_if[g])
    );

    assign bus_if[g].rx_done = done;

    // Valid/ready source walking the shared offer list.
    initial begin : src
      int rd;
      bit fire;
      rd = 0;
      bus_if[g].in_valid = 1'b0;
      bus_if[g].in_id    = '0;
      bus_if[g].in_block = '0;
      forever begin
        @(negedge clk);
        fire = rstn && bus_if[g].in_valid && bus_if[g].in_ready;
        @(posedge clk);
        #1;
        if (fire) rd++;
        if (rd < offers.size()) begin
          bus_if[g].in_valid = 1'b1;
          bus_if[g].in_id    = offers[rd].id;
          bus_if[g].in_block = offers[rd].blk;
        end else begin
          bus_if[g].in_valid = 1'b0;
        end
      end
    end

    // Model: r counts cycles since the accepting handshake cycle.
    initial begin : model
      bit           act;
      bit           errf;
      int           r;
      int           k;
      bit           st;
      bit           vl;
      bit           ls;
      logic [127:0] mblk;
      logic [31:0]  mid;
      logic [15:0]  mcnt;
      logic [7:0]   hold;
      logic [7:0]   dat;
      act  = 0;
      errf = 0;
      r    = 0;
      mblk = '0;
      mid  = '0;
      mcnt = '0;
      hold = '0;
      forever begin
        @(negedge clk);
        if (!rstn) begin
          act  = 0;
          errf = 0;
          r    = 0;
          mid  = '0;
          mcnt = '0;
          hold = '0;
        end
        st  = act && (r == 1);
        vl  = act && (r >= 2) && (((r - 2) % (G + 1)) == 0) && (((r - 2) / (G + 1)) < 16);
        k   = vl ? (r - 2) / (G + 1) : 0;
        dat = vl ? 8'(mblk >> (8 * (15 - k))) : hold;
        ls  = vl && (k == 15);
        chk($sformatf("d%0d in_ready c%0d", g, cyc), bus_if[g].in_ready, !act);
        chk($sformatf("d%0d busy c%0d", g, cyc), bus_if[g].busy, act);
        chk($sformatf("d%0d rx_start c%0d", g, cyc), bus_if[g].rx_start, st);
        chk($sformatf("d%0d rx_valid c%0d", g, cyc), bus_if[g].rx_valid, vl);
        chk($sformatf("d%0d rx_last c%0d", g, cyc), bus_if[g].rx_last, ls);
        chk($sformatf("d%0d rx_data c%0d", g, cyc), bus_if[g].rx_data, dat);
        chk($sformatf("d%0d rx_id c%0d", g, cyc), bus_if[g].rx_id, mid);
        chk($sformatf("d%0d blk_count c%0d", g, cyc), bus_if[g].blk_count, mcnt);
        chk($sformatf("d%0d timeout_err c%0d", g, cyc), bus_if[g].timeout_err, errf);
        hold = dat;
        if (rstn) begin
          errf = 0;
          if (act) begin
            if ((r >= W) && bus_if[g].rx_done) begin
              act  = 0;
              mcnt = mcnt + 16'd1;
            end else if (ToEn && (r == W + ToCyc - 1)) begin
              act  = 0;
              errf = 1;
            end else begin
              r++;
            end
          end else if (bus_if[g].in_valid) begin
            act  = 1;
            r    = 1;
            mblk = bus_if[g].in_block;
            mid  = bus_if[g].in_id;
          end
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rstn   = 1'b1;
    done_at[TA + 30]  = 1'b1;
    done_at[TA + 60]  = 1'b1;
    done_at[TA + 120] = 1'b1;
    done_at[TC + 200] = 1'b1;
    done_at[TD + 81]  = 1'b1;
    done_at[TF + 50]  = 1'b1;
    #1 rstn = 1'b0;

    at_cycle(2);
    chk("reset in_ready", bus_if[0].in_ready, 1'b1);
    chk("reset busy", bus_if[0].busy, 1'b0);
    chk("reset blk_count", bus_if[0].blk_count, 16'h0);
    chk("reset rx_id", bus_if[0].rx_id, 32'h0);
    at_cycle(3);
    @(posedge clk);
    #2 rstn = 1'b1;

    // Block A, then B offered immediately and held through A's wait.
    at_cycle(TA - 1);
    offers.push_back('{id: 32'hA5A5A5A5, blk: BlkA});
    offers.push_back('{id: 32'h000000B2, blk: BlkB});
    at_cycle(TA + 1);
    chk("A start d0", bus_if[0].rx_start, 1'b1);
    chk("A start d1", bus_if[1].rx_start, 1'b1);
    at_cycle(TA + 2);
    chk("A byte0 valid", bus_if[0].rx_valid, 1'b1);
    chk("A byte0 data", bus_if[0].rx_data, 8'h00);
    at_cycle(TA + 5);
    chk("A gap2 byte1 valid", bus_if[1].rx_valid, 1'b1);
    chk("A gap2 byte1 data", bus_if[1].rx_data, 8'h11);
    at_cycle(TA + 16);
    chk("A byte14 data", bus_if[0].rx_data, 8'hEE);
    chk("A byte14 last", bus_if[0].rx_last, 1'b0);
    at_cycle(TA + 17);
    chk("A byte15 data", bus_if[0].rx_data, 8'hFF);
    chk("A byte15 last", bus_if[0].rx_last, 1'b1);
    chk("A rx_id", bus_if[0].rx_id, 32'hA5A5A5A5);
    at_cycle(TA + 30);
    chk("A held off", bus_if[0].in_ready, 1'b0);
    at_cycle(TA + 31);
    chk("A done ready", bus_if[0].in_ready, 1'b1);
    chk("A done count", bus_if[0].blk_count, 16'd1);
    chk("A gap2 ignores early done", bus_if[1].in_ready, 1'b0);
    at_cycle(TA + 33);
    chk("B rx_id", bus_if[0].rx_id, 32'h000000B2);
    chk("B byte0 data", bus_if[0].rx_data, 8'hF0);
    at_cycle(TA + 47);
    chk("A gap2 last", bus_if[1].rx_last, 1'b1);
    chk("A gap2 last data", bus_if[1].rx_data, 8'hFF);
    at_cycle(TA + 61);
    chk("B count d0", bus_if[0].blk_count, 16'd2);
    chk("A count d1", bus_if[1].blk_count, 16'd1);
    at_cycle(TA + 121);
    chk("B count d1", bus_if[1].blk_count, 16'd2);

    // Block C with rx_done withheld long past the timeout window.
    at_cycle(TC - 1);
    offers.push_back('{id: 32'hC0C00001, blk: BlkC});
`ifdef TX_TIMEOUT_EN
    at_cycle(TC + 81);
    chk("C no early timeout", bus_if[0].timeout_err, 1'b0);
    at_cycle(TC + 82);
    chk("C timeout pulse", bus_if[0].timeout_err, 1'b1);
    chk("C timeout count", bus_if[0].blk_count, 16'd2);
    at_cycle(TC + 83);
    chk("C timeout single", bus_if[0].timeout_err, 1'b0);
    chk("C timeout ready", bus_if[0].in_ready, 1'b1);
`else
    at_cycle(TC + 82);
    chk("C no timeout", bus_if[0].timeout_err, 1'b0);
    chk("C still busy", bus_if[0].busy, 1'b1);
`endif

    // Block D: rx_done lands on the last cycle of the timeout window.
    at_cycle(TD - 1);
    offers.push_back('{id: 32'hD0D00002, blk: BlkB});
    at_cycle(TD + 82);
    chk("D count", bus_if[0].blk_count, ToEn ? 16'd3 : 16'd4);
    chk("D no error", bus_if[0].timeout_err, 1'b0);

    // Block E aborted by reset during byte 7, then F from byte 0.
    at_cycle(TE - 1);
    offers.push_back('{id: 32'h0E0E0E0E, blk: BlkA});
    at_cycle(TE + 8);
    chk("E byte6 data", bus_if[0].rx_data, 8'h66);
    @(posedge clk);
    #2 rstn = 1'b0;
    at_cycle(TE + 9);
    chk("E reset valid", bus_if[0].rx_valid, 1'b0);
    chk("E reset data", bus_if[0].rx_data, 8'h00);
    chk("E reset count", bus_if[0].blk_count, 16'h0);
    chk("E reset ready", bus_if[0].in_ready, 1'b1);
    at_cycle(TE + 10);
    @(posedge clk);
    #2 rstn = 1'b1;
    at_cycle(TF - 1);
    offers.push_back('{id: 32'h12345678, blk: BlkA});
    at_cycle(TF + 1);
    chk("F start", bus_if[0].rx_start, 1'b1);
    chk("F rx_id", bus_if[0].rx_id, 32'h12345678);
    at_cycle(TF + 2);
    chk("F byte0 data", bus_if[0].rx_data, 8'h00);
    at_cycle(TF + 51);
    chk("F count d0", bus_if[0].blk_count, 16'd1);
    chk("F count d1", bus_if[1].blk_count, 16'd1);

    at_cycle(TF + 60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
